// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: packs a big-endian byte stream into
// 32-bit words and writes them at consecutive word addresses from BASE_ADDR.
module instruction_loader #(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] words_written
);

    // Wide enough that BASE_ADDR + 4*num_words can never wrap.
    localparam int unsigned RW = CNT_WIDTH + 34;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_idx;
    logic [31:0]            r_word;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   r_words;
    logic                   r_in_ready;
    logic                   r_mem_we;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_wdata;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    logic [RW-1:0]          w_end;
    logic                   w_overflow;
    logic [31:0]            w_next_word;
    logic [CNT_WIDTH-1:0]   w_next_cnt;
    logic [31:0]            w_addr;
    logic                   w_accept;

    assign w_end       = RW'(BASE_ADDR) + (RW'(num_words) << 2);
    assign w_overflow  = w_end > RW'(MEM_BYTES);
    assign w_next_word = {r_word[23:0], in_byte};
    assign w_next_cnt  = r_words + CNT_WIDTH'(1);
    assign w_addr      = 32'(BASE_ADDR) + (32'(r_words) << 2);
    assign w_accept    = in_valid && r_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_word      <= '0;
            r_num       <= '0;
            r_words     <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num   <= num_words;
                        r_words <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        if (num_words == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_overflow) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_COLLECT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_word <= w_next_word;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state     <= S_WRITE;
                            r_in_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_next_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= w_next_cnt;
                    if (w_next_cnt == r_num) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= S_COLLECT;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader; expected writes are
// derived from the byte list (address = base + 4k, big-endian packing).
module tb_instruction_loader;

    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned CNT_WIDTH = 7;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [CNT_WIDTH-1:0] num_words = '0;
    logic [7:0]           in_byte = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [CNT_WIDTH-1:0] words_written;

    instruction_loader #(
        .MEM_BYTES(MEM_BYTES),
        .BASE_ADDR(BASE_ADDR),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_words(num_words),
        .in_byte(in_byte),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] mem_model [0:63];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_we_cyc = 0;
    int rdy_cnt = 0;
    int rdy_in_write = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                mem_model[mem_addr[7:2]] = mem_wdata;
                last_we_cyc = cyc;
                if (in_ready) rdy_in_write++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (in_ready) rdy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        rdy_cnt = 0;
        rdy_in_write = 0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
        int idx = 0;
        int budget = 0;
        int gap;
        bit acc;
        while (idx < q.size() && budget < 2000) begin
            gap = int'($urandom_range(0, maxgap));
            in_valid = 1'b0;
            in_byte = 8'($urandom);
            repeat (gap) tick();
            budget += gap;
            in_valid = 1'b1;
            in_byte = q[idx];
            acc = 1'b0;
            while (!acc && budget < 2000) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                budget++;
            end
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check_eq("bytes_sent", 32'(idx), 32'(q.size()));
    endtask

    task automatic wait_done();
        int b = 0;
        while (done_cnt == 0 && b < 500) begin
            tick();
            b++;
        end
        repeat (3) tick();
    endtask

    task automatic do_load(input int n, input logic [7:0] bytes[$], input int maxgap, input bit busy_start);
        bit exp_err;
        int exp_w;
        int start_cyc;
        logic [31:0] exp_data;
        clear_mon();
        exp_err = (BASE_ADDR + 4 * n) > MEM_BYTES;
        exp_w = exp_err ? 0 : n;
        start = 1'b1;
        num_words = CNT_WIDTH'(n);
        start_cyc = cyc;
        tick();
        start = 1'b0;
        num_words = CNT_WIDTH'($urandom);
        if (busy_start) begin
            repeat (2) tick();
            start = 1'b1;
            num_words = CNT_WIDTH'(5);
            tick();
            start = 1'b0;
        end
        if (exp_w > 0) begin
            send_bytes(bytes, maxgap);
        end else begin
            in_valid = 1'b1;
            in_byte = 8'hAA;
        end
        wait_done();
        in_valid = 1'b0;
        for (int k = 0; k < exp_w && k < got_addr.size(); k++) begin
            exp_data = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
            check_eq("wr_addr", got_addr[k], BASE_ADDR + 32'(4 * k));
            check_eq("wr_data", got_data[k], exp_data);
        end
        check_eq("wr_count", 32'(got_addr.size()), 32'(exp_w));
        check_eq("error", 32'(error), 32'(exp_err));
        check_eq("words_written", 32'(words_written), 32'(exp_w));
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("rdy_in_write", 32'(rdy_in_write), 32'd0);
        if (exp_w == 0) begin
            check_eq("done_latency0", 32'(done_cyc), 32'(start_cyc + 1));
            check_eq("rdy_never", 32'(rdy_cnt), 32'd0);
        end else begin
            check_eq("done_latency", 32'(done_cyc), 32'(last_we_cyc + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] empty_q[$];
        int n;

        repeat (3) tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_words", 32'(words_written), 32'd0);
        rst = 1'b1;
        tick();

        q = {8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h1A, 8'h01};
        do_load(2, q, 0, 1'b0);
        do_load(2, q, 5, 1'b0);

        do_load(0, empty_q, 0, 1'b0);
        do_load(65, empty_q, 0, 1'b0);
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        do_load(1, q, 2, 1'b0);

        // Reset in the middle of a 3-word load, after 6 bytes.
        clear_mon();
        start = 1'b1;
        num_words = CNT_WIDTH'(3);
        tick();
        start = 1'b0;
        q = {8'hE3, 8'hA0, 8'h00, 8'h14, 8'h5A, 8'hC3};
        send_bytes(q, 0);
        rst = 1'b0;
        tick();
        check_eq("mr_in_ready", 32'(in_ready), 32'd0);
        check_eq("mr_mem_we", 32'(mem_we), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_done", 32'(done), 32'd0);
        check_eq("mr_error", 32'(error), 32'd0);
        check_eq("mr_addr", mem_addr, 32'd0);
        check_eq("mr_wdata", mem_wdata, 32'd0);
        check_eq("mr_words", 32'(words_written), 32'd0);
        check_eq("mr_wr_count", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) begin
            check_eq("mr_wr_addr", got_addr[0], 32'd0);
            check_eq("mr_wr_data", got_data[0], 32'hE3A00014);
        end
        rst = 1'b1;
        tick();
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load(1, q, 1, 1'b0);

        q = {8'h01, 8'h02, 8'h03, 8'h04};
        do_load(1, q, 0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 8));
            q.delete();
            for (int b = 0; b < 4 * n; b++) q.push_back(8'($urandom));
            do_load(n, q, 3, 1'b0);
        end

        q.delete();
        for (int b = 0; b < 256; b++) q.push_back(8'(b));
        do_load(64, q, 0, 1'b0);
        check_eq("full_last_addr", got_addr[got_addr.size() - 1], 32'd252);
        check_eq("full_last_data", got_data[got_data.size() - 1], 32'hFCFDFEFF);
        check_eq("full_mem0", mem_model[0], 32'h00010203);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
